// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync
// Takes asynchronous board switch/button levels into clk, debounces each
// channel independently and presents registered clean levels, one-cycle
// change pulses and an overall "nothing is settling" status flag.
module switch_debounce_sync #(
  parameter int N_CH            = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_clean,
  output logic [N_CH-1:0] sw_changed,
  output logic            all_stable
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so
  // the degenerate DEBOUNCE_CYCLES==1 build still has a legal vector.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  logic [N_CH-1:0] ch_stable;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   clean_q;
    logic                   clean_d;
    logic                   changed_q;
    logic                   changed_d;
    logic                   syn;

    // Synchronised level: last stage of the chain, the only thing the FSM looks at.
    assign syn = sync_q[SYNC_STAGES-1];

    // Shift chain: stage 0 captures the raw pin, each later stage follows the previous one.
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw[gi]};
    end

    // Debounce FSM next-state: count consecutive mismatch cycles, accept once
    // the run is long enough, abandon the run on any match (bounce).
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clean_d   = clean_q;
      changed_d = 1'b0;
      case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (syn != clean_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // A single mismatch cycle is already enough: accept immediately.
              clean_d   = syn;
              changed_d = 1'b1;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = ST_COUNTING;
            end
          end
        end
        ST_COUNTING: begin
          if (syn == clean_q) begin
            // Level went back before the run completed: drop it silently.
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q == CNT_LAST) begin
            // Checked before incrementing so the counter never wraps.
            clean_d   = syn;
            changed_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
    end

    // State registers; reset wins over any count in progress.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q    <= '0;
        state_q   <= ST_STABLE;
        cnt_q     <= '0;
        clean_q   <= 1'b0;
        changed_q <= 1'b0;
      end else begin
        sync_q    <= sync_d;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        clean_q   <= clean_d;
        changed_q <= changed_d;
      end
    end

    assign sw_clean[gi]   = clean_q;
    assign sw_changed[gi] = changed_q;
    assign ch_stable[gi]  = (state_q == ST_STABLE);
  end

  // Status: high only when no channel is part-way through a mismatch run.
  assign all_stable = &ch_stable;

endmodule
